// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential signed BCD-to-binary converter.
// Reverse double-dabble, one shift per cycle, start/busy/done handshake.
// Optional macro SIGNED_OUT_EN: bin becomes BIN_W+1 bits two's complement.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  neg_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef SIGNED_OUT_EN
    output logic [BIN_W:0]        bin,
`else
    output logic [BIN_W-1:0]      bin,
`endif
    output logic                  neg_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
`ifdef SIGNED_OUT_EN
    localparam int OUT_W = BIN_W + 1;
`else
    localparam int OUT_W = BIN_W;
`endif
    localparam longint MAX_VAL = (longint'(10) ** DIGITS) - 1;

    // Result width must hold the largest decimal operand.
    generate
        if ((longint'(1) << BIN_W) <= MAX_VAL) begin : g_width_check
            $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg, state_next;
    logic [SR_W-1:0]    sr_reg, sr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               neg_reg, neg_next;
    logic [OUT_W-1:0]   bin_reg, bin_next;
    logic               err_reg, err_next;
    logic               neg_out_reg, neg_out_next;

    logic [DIGITS-1:0]  digit_bad;
    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_adj;
    logic [BIN_W-1:0]   mag;
    logic               mag_neg;

    assign sr_shift = sr_reg >> 1;
    assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    // Per-digit validity check and post-shift nibble correction.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            assign digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
            assign nib = sr_shift[BIN_W + 4*gi +: 4];
            assign sr_adj[BIN_W + 4*gi +: 4] = (nib >= 4'd8) ? nib - 4'd3 : nib;
        end
    endgenerate

    // Magnitude after the final shift; negative zero is suppressed.
    assign mag     = sr_adj[BIN_W-1:0];
    assign mag_neg = neg_reg & (mag != '0);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            sr_reg      <= '0;
            count_reg   <= '0;
            neg_reg     <= 1'b0;
            bin_reg     <= '0;
            err_reg     <= 1'b0;
            neg_out_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sr_reg      <= sr_next;
            count_reg   <= count_next;
            neg_reg     <= neg_next;
            bin_reg     <= bin_next;
            err_reg     <= err_next;
            neg_out_reg <= neg_out_next;
        end
    end

    // Next-state and result logic; results are loaded on entry to DONE.
    always_comb begin
        state_next   = state_reg;
        sr_next      = sr_reg;
        count_next   = count_reg;
        neg_next     = neg_reg;
        bin_next     = bin_reg;
        err_next     = err_reg;
        neg_out_next = neg_out_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    neg_next = neg_in;
                    sr_next  = {bcd_in, {BIN_W{1'b0}}};
                    if (|digit_bad) begin
                        err_next     = 1'b1;
                        bin_next     = '0;
                        neg_out_next = 1'b0;
                        state_next   = DONE;
                    end else begin
                        count_next = CNT_W'(BIN_W);
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_next    = sr_adj;
                count_next = count_reg - 1'b1;
                if (count_reg == CNT_W'(1)) begin
                    err_next     = 1'b0;
                    neg_out_next = mag_neg;
`ifdef SIGNED_OUT_EN
                    bin_next     = mag_neg ? -{1'b0, mag} : {1'b0, mag};
`else
                    bin_next     = mag;
`endif
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign err     = err_reg;
    assign bin     = bin_reg;
    assign neg_out = neg_out_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_bin_seq;

`ifdef SIGNED_OUT_EN
    localparam int BW = 11;
`else
    localparam int BW = 10;
`endif

`define CHK(tag, obs, exp) \
    tests++; \
    assert ((obs) === (exp)) else begin \
        fails++; \
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [11:0]   bcd_in = '0;
    logic          neg_in = 1'b0;
    logic          busy, done, err, neg_out;
    logic [BW-1:0] bin;

    int tests = 0;
    int fails = 0;

    bcd_to_bin_seq dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in), .neg_in(neg_in),
        .busy(busy), .done(done), .err(err), .bin(bin), .neg_out(neg_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal value of the digits, plain arithmetic.
    task automatic ref_conv(input logic [11:0] b, input logic n,
                            output logic e, output logic [BW-1:0] r,
                            output logic no, output int cyc);
        int v = 0;
        int scale = 1;
        e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int d = int'(b[4*i +: 4]);
            if (d > 9) e = 1'b1;
            v += d * scale;
            scale *= 10;
        end
        if (e) begin
            r = '0; no = 1'b0; cyc = 1;
        end else begin
            no = n && (v != 0);
`ifdef SIGNED_OUT_EN
            r = no ? BW'(-v) : BW'(v);
`else
            r = BW'(v);
`endif
            cyc = 11;
        end
    endtask

    // Wait for done starting from cycle c0; bounded.
    task automatic wait_done(input int c0, output int dc, output int busy_low);
        dc = -1;
        busy_low = 0;
        for (int c = c0; c <= c0 + 25; c++) begin
            if (!busy) busy_low++;
            if (done) begin
                dc = c;
                break;
            end
            tick();
        end
        tests++;
        if (dc < 0) begin
            fails++;
            $error("FAIL wait_done timeout: no done within %0d cycles of cycle %0d", 26, c0);
        end
    endtask

    task automatic do_conv(input logic [11:0] b, input logic n,
                           output int dc, output int busy_low);
        start = 1'b1; bcd_in = b; neg_in = n;
        tick();
        start = 1'b0;
        wait_done(1, dc, busy_low);
    endtask

    task automatic run_check(input logic [11:0] b, input logic n);
        logic e_e, e_no;
        logic [BW-1:0] e_r;
        int e_c, dc, bl;
        ref_conv(b, n, e_e, e_r, e_no, e_c);
        do_conv(b, n, dc, bl);
        `CHK("done_cycle", dc, e_c)
        `CHK("busy_before_done", bl, 0)
        `CHK("bin", bin, e_r)
        `CHK("err", err, e_e)
        `CHK("neg_out", neg_out, e_no)
        $display("[TB] bcd=%03h neg=%0b -> bin=%0h err=%0b neg_out=%0b done@%0d",
                 b, n, bin, err, neg_out, dc);
        tick();
        `CHK("idle_after_done", busy, 1'b0)
    endtask

    initial begin
        int dc, bl;
        int dcs[$];
        logic [11:0] rb;

        // Reset state
        repeat (3) tick();
        tests++;
        if ({busy, done, err, neg_out} !== 4'b0000 || bin !== BW'(0)) begin
            fails++;
            $error("FAIL reset_state observed busy=%0b done=%0b err=%0b neg_out=%0b bin=%0h expected all 0",
                   busy, done, err, neg_out, bin);
        end
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_err", err, 1'b0)
        `CHK("rst_bin", bin, BW'(0))
        `CHK("rst_neg", neg_out, 1'b0)
        $display("[TB] reset: busy=%0b done=%0b err=%0b bin=%0h neg_out=%0b",
                 busy, done, err, bin, neg_out);
        rst = 1'b0;
        tick();

        // Directed cases
        run_check(12'h165, 1'b1);
        run_check(12'h165, 1'b0);
        run_check(12'h999, 1'b0);
        run_check(12'h000, 1'b1);
        run_check(12'h16A, 1'b0);
        run_check(12'h042, 1'b0);
        run_check(12'hF00, 1'b1);
        run_check(12'h001, 1'b1);

        // Start re-pulsed mid-conversion is ignored
        start = 1'b1; bcd_in = 12'h165; neg_in = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; bcd_in = 12'h042; neg_in = 1'b0;
        tick();
        start = 1'b0;
        wait_done(5, dc, bl);
        `CHK("repulse_done_cycle", dc, 11)
`ifdef SIGNED_OUT_EN
        `CHK("repulse_bin", bin, BW'(-165))
`else
        `CHK("repulse_bin", bin, BW'(165))
`endif
        `CHK("repulse_neg", neg_out, 1'b1)
        $display("[TB] repulse: bin=%0h done@%0d", bin, dc);
        tick();

        // Reset mid-SHIFT aborts, outputs cleared
        start = 1'b1; bcd_in = 12'h321; neg_in = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        `CHK("abort_busy", busy, 1'b0)
        `CHK("abort_done", done, 1'b0)
        `CHK("abort_bin", bin, BW'(0))
        `CHK("abort_neg", neg_out, 1'b0)
        `CHK("abort_err", err, 1'b0)
        bl = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) bl++;
            tick();
        end
        `CHK("abort_no_done", bl, 0)
        $display("[TB] mid-run reset: outputs cleared, no done");

        // Start held high: second conversion accepted in first IDLE after DONE
        start = 1'b1; bcd_in = 12'h250; neg_in = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done) dcs.push_back(c);
        end
        start = 1'b0;
        `CHK("held_done_count", dcs.size(), 2)
        if (dcs.size() == 2) begin
            `CHK("held_first", dcs[0], 11)
            `CHK("held_second", dcs[1], 23)
        end
        `CHK("held_bin", bin, BW'(250))
        $display("[TB] start held: %0d done pulses", dcs.size());
        repeat (14) tick();

        // Randomized operands, occasionally invalid
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 3; i++)
                rb[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 9));
            run_check(rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
